// File: rtl/arr_packer.sv
// Stream-to-array packer: collects up to N_WORDS words from a valid/ready stream
// into one zero-padded frame, with a per-word odd mask and real-word count.
//
// state | meaning
// ------+------------------------------------------------------------------
// FILL  | accepting words into slot idx; in_ready=1
// HOLD  | complete frame presented on arr/odd_mask/word_cnt; waiting for out_ready
module arr_packer #(
    parameter int N_WORDS = 5,
    parameter int W       = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [W-1:0]         in_data,
    input  logic                 in_valid,
    input  logic                 in_last,
    output logic                 in_ready,
    output logic [N_WORDS*W-1:0] arr,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [N_WORDS-1:0]   odd_mask,
    output logic [2:0]           word_cnt
);

    localparam logic [2:0] LAST_IDX = 3'(N_WORDS - 1);

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t                 state, state_nx;
    logic [2:0]             idx, idx_nx;
    logic [N_WORDS*W-1:0]   arr_nx;
    logic [N_WORDS-1:0]     mask_nx;
    logic [2:0]             cnt_nx;
    logic                   ovld_nx;
    logic                   accept;
    logic                   close;

    assign in_ready = (state == FILL);
    assign accept   = in_valid && in_ready;
    assign close    = (idx == LAST_IDX) || in_last;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= FILL;
            idx       <= '0;
            arr       <= '0;
            odd_mask  <= '0;
            word_cnt  <= '0;
            out_valid <= 1'b0;
        end else begin
            state     <= state_nx;
            idx       <= idx_nx;
            arr       <= arr_nx;
            odd_mask  <= mask_nx;
            word_cnt  <= cnt_nx;
            out_valid <= ovld_nx;
        end
    end

    always_comb begin
        state_nx = state;
        idx_nx   = idx;
        arr_nx   = arr;
        mask_nx  = odd_mask;
        cnt_nx   = word_cnt;
        ovld_nx  = out_valid;
        case (state)
            FILL: begin
                if (accept) begin
                    // Slots below idx keep this frame's words; slots above idx are
                    // only zeroed when the frame closes, so stale data never escapes.
                    for (int k = 0; k < N_WORDS; k++) begin
                        if (3'(k) == idx) begin
                            arr_nx[k*W +: W] = in_data;
                            mask_nx[k]       = in_data[0];
                        end else if (close && (3'(k) > idx)) begin
                            arr_nx[k*W +: W] = '0;
                            mask_nx[k]       = 1'b0;
                        end
                    end
                    if (close) begin
                        cnt_nx   = idx + 3'd1;
                        ovld_nx  = 1'b1;
                        idx_nx   = '0;
                        state_nx = HOLD;
                    end else begin
                        idx_nx = idx + 3'd1;
                    end
                end
            end
            HOLD: begin
                if (out_ready) begin
                    ovld_nx  = 1'b0;
                    state_nx = FILL;
                end
            end
            default: state_nx = FILL;
        endcase
    end

endmodule

// File: tb/tb_arr_packer.sv
// Directed bench for arr_packer: table of per-cycle vectors with expected
// outputs after each edge, plus hand-written gap and single-word sequences.
module tb_arr_packer;

    logic         clk = 1'b0;
    logic         rst;
    logic [31:0]  in_data;
    logic         in_valid;
    logic         in_last;
    logic         in_ready;
    logic [159:0] arr;
    logic         out_valid;
    logic         out_ready;
    logic [4:0]   odd_mask;
    logic [2:0]   word_cnt;

    int n_vec = 0;
    int n_err = 0;

    arr_packer #(.N_WORDS(5), .W(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .arr       (arr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .odd_mask  (odd_mask),
        .word_cnt  (word_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         r;
        logic         v;
        logic         l;
        logic [31:0]  d;
        logic         o;
        logic         e_irdy;
        logic         e_ovld;
        logic [159:0] e_arr;
        logic [4:0]   e_mask;
        logic [2:0]   e_cnt;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [159:0] pk(input logic [31:0] w0, w1, w2, w3, w4);
        return {w4, w3, w2, w1, w0};
    endfunction

    task automatic add(input logic r, v, l, input logic [31:0] d, input logic o,
                       input logic ei, eo, input logic [159:0] ea,
                       input logic [4:0] em, input logic [2:0] ec);
        vec_t t;
        t.r = r; t.v = v; t.l = l; t.d = d; t.o = o;
        t.e_irdy = ei; t.e_ovld = eo; t.e_arr = ea; t.e_mask = em; t.e_cnt = ec;
        vecs.push_back(t);
    endtask

    task automatic drive(input logic r, v, l, input logic [31:0] d, input logic o);
        rst = r; in_valid = v; in_last = l; in_data = d; out_ready = o;
    endtask

    task automatic check(input string tag, input logic ei, eo, input logic [159:0] ea,
                         input logic [4:0] em, input logic [2:0] ec);
        n_vec++;
        if (in_ready !== ei) begin
            n_err++;
            $display("FAIL %s in_ready got %b want %b", tag, in_ready, ei);
        end
        if (out_valid !== eo) begin
            n_err++;
            $display("FAIL %s out_valid got %b want %b", tag, out_valid, eo);
        end
        if (arr !== ea) begin
            n_err++;
            $display("FAIL %s arr got %h want %h", tag, arr, ea);
        end
        if (odd_mask !== em) begin
            n_err++;
            $display("FAIL %s odd_mask got %b want %b", tag, odd_mask, em);
        end
        if (word_cnt !== ec) begin
            n_err++;
            $display("FAIL %s word_cnt got %0d want %0d", tag, word_cnt, ec);
        end
    endtask

    task automatic step(input logic r, v, l, input logic [31:0] d, input logic o);
        drive(r, v, l, d, o);
        @(posedge clk);
        #1;
    endtask

    logic [31:0]  gap_words [5];
    logic [159:0] f1, f2, f2d, f4;

    initial begin
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);

        f1  = pk(3, 5, 4, 7, 9);
        f2  = pk(6, 11, 0, 0, 0);
        f2d = pk(32'hDEAD, 11, 0, 0, 0);
        f4  = pk(1, 3, 5, 7, 9);

        //  r  v  l  data        o    irdy ovld arr                       mask      cnt
        add(1, 0, 0, 32'h0,      0,   1,   0,   '0,                       5'b00000, 0);
        add(0, 0, 0, 32'h0,      1,   1,   0,   '0,                       5'b00000, 0);
        add(0, 1, 0, 32'd3,      1,   1,   0,   pk(3, 0, 0, 0, 0),        5'b00001, 0);
        add(0, 1, 0, 32'd5,      1,   1,   0,   pk(3, 5, 0, 0, 0),        5'b00011, 0);
        add(0, 1, 0, 32'd4,      1,   1,   0,   pk(3, 5, 4, 0, 0),        5'b00011, 0);
        add(0, 1, 0, 32'd7,      1,   1,   0,   pk(3, 5, 4, 7, 0),        5'b01011, 0);
        add(0, 1, 0, 32'd9,      1,   0,   1,   f1,                       5'b11011, 5);
        add(0, 0, 0, 32'h0,      1,   1,   0,   f1,                       5'b11011, 5);
        add(0, 1, 0, 32'd6,      0,   1,   0,   pk(6, 5, 4, 7, 9),        5'b11010, 5);
        add(0, 1, 1, 32'd11,     0,   0,   1,   f2,                       5'b00010, 2);
        for (int i = 0; i < 4; i++)
            add(0, 1, 0, 32'hDEAD, 0, 0,   1,   f2,                       5'b00010, 2);
        add(0, 1, 0, 32'hDEAD,   1,   1,   0,   f2,                       5'b00010, 2);
        add(0, 1, 0, 32'hDEAD,   0,   1,   0,   f2d,                      5'b00011, 2);
        add(0, 1, 0, 32'd2,      0,   1,   0,   pk(32'hDEAD, 2, 0, 0, 0), 5'b00001, 2);
        add(1, 1, 0, 32'd77,     0,   1,   0,   '0,                       5'b00000, 0);
        add(0, 1, 0, 32'd1,      0,   1,   0,   pk(1, 0, 0, 0, 0),        5'b00001, 0);
        add(0, 1, 0, 32'd3,      0,   1,   0,   pk(1, 3, 0, 0, 0),        5'b00011, 0);
        add(0, 1, 0, 32'd5,      0,   1,   0,   pk(1, 3, 5, 0, 0),        5'b00111, 0);
        add(0, 1, 0, 32'd7,      0,   1,   0,   pk(1, 3, 5, 7, 0),        5'b01111, 0);
        add(0, 1, 0, 32'd9,      0,   0,   1,   f4,                       5'b11111, 5);
        add(0, 0, 0, 32'h0,      1,   1,   0,   f4,                       5'b11111, 5);
        add(0, 1, 1, 32'd8,      0,   0,   1,   pk(8, 0, 0, 0, 0),        5'b00000, 1);
        add(1, 0, 0, 32'h0,      0,   1,   0,   '0,                       5'b00000, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].r, vecs[i].v, vecs[i].l, vecs[i].d, vecs[i].o);
            check($sformatf("vec%0d", i), vecs[i].e_irdy, vecs[i].e_ovld,
                  vecs[i].e_arr, vecs[i].e_mask, vecs[i].e_cnt);
        end

        // Random idle gaps between words; in_last on the fifth word is redundant.
        gap_words[0] = 32'hFFFFFFFF;
        gap_words[1] = 32'h80000000;
        gap_words[2] = 32'h00000001;
        gap_words[3] = 32'h00000002;
        gap_words[4] = 32'h7FFFFFFF;
        for (int i = 0; i < 5; i++) begin
            for (int g = 0; g < 3; g++) begin
                if ($urandom_range(0, 1) == 0) break;
                step(1'b0, 1'b0, 1'b0, 32'h5555AAAA, 1'b1);
            end
            step(1'b0, 1'b1, (i == 4), gap_words[i], 1'b1);
        end
        check("gap_frame", 1'b0, 1'b1,
              pk(32'hFFFFFFFF, 32'h80000000, 1, 2, 32'h7FFFFFFF), 5'b10101, 3'd5);
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        check("gap_release", 1'b1, 1'b0,
              pk(32'hFFFFFFFF, 32'h80000000, 1, 2, 32'h7FFFFFFF), 5'b10101, 3'd5);

        // Single-word frame: upper four slots must be zero-padded.
        step(1'b0, 1'b1, 1'b1, 32'h00000001, 1'b0);
        check("single_word", 1'b0, 1'b1, pk(1, 0, 0, 0, 0), 5'b00001, 3'd1);
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        check("single_release", 1'b1, 1'b0, pk(1, 0, 0, 0, 0), 5'b00001, 3'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
